// File: rtl/note_player_multi.sv
// note_player_multi: multi-voice note state with a shared-ROM round-robin fetch sequencer.
// Define NOTE_PLAYER_LEGATO_EN to keep the envelope step on same-instrument reloads.
module note_player_multi #(
  parameter int CHANNELS = 4,
  parameter int PITCH_W  = 6,
  parameter int DUR_W    = 5,
  parameter int INSTR_W  = 4,
  parameter int ENV_W    = 9,
  parameter int ROM_AW   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tick,
  input  logic [CHANNELS-1:0]           i_load,
  input  logic [CHANNELS*PITCH_W-1:0]   i_pitch,
  input  logic [CHANNELS*DUR_W-1:0]     i_duration,
  input  logic [CHANNELS*INSTR_W-1:0]   i_instrument,
  output logic [CHANNELS-1:0]           o_done,
  output logic [CHANNELS*32-1:0]        o_phase_delta,
  output logic [CHANNELS*ENV_W-1:0]     o_envelope,
  output logic                          o_busy,
  output logic [ROM_AW-1:0]             o_rom_addr,
  input  logic [15:0]                   i_rom_data
);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_PD_HI = 3'd1, S_PD_LO = 3'd2,
                         S_PD_CAP = 3'd3, S_ENV_A = 3'd4, S_ENV_CAP = 3'd5;
  logic [PITCH_W-1:0]  r_pitch [CHANNELS];
  logic [INSTR_W-1:0]  r_instr [CHANNELS];
  logic [DUR_W-1:0]    r_rem   [CHANNELS];
  logic [2:0]          r_step  [CHANNELS];
  logic [31:0]         r_pd    [CHANNELS];
  logic [ENV_W-1:0]    r_env   [CHANNELS];
  logic [CHANNELS-1:0] r_active, r_pd_pend, r_env_pend, r_done;
  logic [2:0]          r_state;
  logic [CW-1:0]       r_ch, r_rr;
  logic [15:0]         r_hi;
  logic                r_abort;
  logic [ROM_AW-1:0]   r_addr;
  logic                w_found, w_ok;
  logic [CW-1:0]       w_pick;
  logic [CHANNELS-1:0] w_end, w_kill, w_legato;
  logic [ROM_AW-1:0]   w_addr;
  always_comb begin
    w_end = '0;
    w_kill = '0;
    w_legato = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_end[c] = i_tick && r_active[c] && !i_load[c] && r_rem[c] == DUR_W'(1);
      w_kill[c] = w_end[c] || i_load[c];
`ifdef NOTE_PLAYER_LEGATO_EN
      w_legato[c] = r_active[c] && i_instrument[c*INSTR_W +: INSTR_W] == r_instr[c];
`else
      w_legato[c] = 1'b0;
`endif
    end
  end
  always_comb begin
    w_found = 1'b0;
    w_pick = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!w_found && (r_pd_pend[CW'((int'(r_rr) + k) % CHANNELS)] || r_env_pend[CW'((int'(r_rr) + k) % CHANNELS)])) begin
        w_found = 1'b1;
        w_pick = CW'((int'(r_rr) + k) % CHANNELS);
      end
    end
  end
  // Address follows the serviced channel's live state; IDLE replays the last address.
  assign w_addr = r_state == S_PD_HI ? {1'b0, r_pitch[r_ch], 1'b0} :
                  r_state == S_PD_LO ? {1'b0, r_pitch[r_ch], 1'b1} :
                  r_state == S_ENV_A ? {1'b1, r_instr[r_ch], r_step[r_ch]} : r_addr;
  assign w_ok = r_active[r_ch] && !r_abort && !w_kill[r_ch];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ch <= '0;
      r_rr <= '0;
      r_hi <= '0;
      r_abort <= 1'b0;
      r_addr <= '0;
      r_active <= '0;
      r_pd_pend <= '0;
      r_env_pend <= '0;
      r_done <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_pitch[c] <= '0;
        r_instr[c] <= '0;
        r_rem[c] <= '0;
        r_step[c] <= '0;
        r_pd[c] <= '0;
        r_env[c] <= '0;
      end
    end else begin
      r_addr <= w_addr;
      r_done <= '0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_ch <= w_pick;
          r_abort <= 1'b0;
          r_pd_pend[w_pick] <= 1'b0;
          r_env_pend[w_pick] <= 1'b0;
          r_state <= r_pd_pend[w_pick] ? S_PD_HI : S_ENV_A;
        end
        S_PD_HI: r_state <= S_PD_LO;
        S_PD_LO: begin
          r_hi <= i_rom_data;
          r_state <= S_PD_CAP;
        end
        S_PD_CAP: begin
          if (w_ok) r_pd[r_ch] <= {r_hi, i_rom_data};
          r_state <= S_ENV_A;
        end
        S_ENV_A: r_state <= S_ENV_CAP;
        S_ENV_CAP: begin
          if (w_ok) r_env[r_ch] <= i_rom_data[ENV_W-1:0];
          r_rr <= r_ch == CW'(CHANNELS - 1) ? '0 : r_ch + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_state != S_IDLE && w_kill[r_ch]) r_abort <= 1'b1;
      // Channel updates come last so a load/tick flag set beats the pick-time clear.
      for (int c = 0; c < CHANNELS; c++) begin
        if (i_load[c]) begin
          r_pitch[c] <= i_pitch[c*PITCH_W +: PITCH_W];
          r_instr[c] <= i_instrument[c*INSTR_W +: INSTR_W];
          r_rem[c] <= i_duration[c*DUR_W +: DUR_W];
          if (!w_legato[c]) r_step[c] <= '0;
          if (i_duration[c*DUR_W +: DUR_W] == '0) begin
            r_active[c] <= 1'b0;
            r_done[c] <= 1'b1;
            r_env[c] <= '0;
            r_pd_pend[c] <= 1'b0;
            r_env_pend[c] <= 1'b0;
          end else begin
            r_active[c] <= 1'b1;
            r_pd_pend[c] <= 1'b1;
            if (!w_legato[c]) r_env_pend[c] <= 1'b1;
          end
        end else if (i_tick && r_active[c]) begin
          r_rem[c] <= r_rem[c] - 1'b1;
          if (w_end[c]) begin
            r_active[c] <= 1'b0;
            r_done[c] <= 1'b1;
            r_env[c] <= '0;
            r_pd_pend[c] <= 1'b0;
            r_env_pend[c] <= 1'b0;
          end else begin
            r_step[c] <= r_step[c] == 3'd7 ? 3'd7 : r_step[c] + 3'd1;
            r_env_pend[c] <= 1'b1;
          end
        end
      end
    end
  end
  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_out
      assign o_phase_delta[g*32 +: 32] = r_pd[g];
      assign o_envelope[g*ENV_W +: ENV_W] = r_env[g];
    end
  endgenerate
  assign o_done = r_done;
  assign o_busy = r_state != S_IDLE;
  assign o_rom_addr = w_addr;
endmodule
